// File: rtl/pc_sequencer_pkg.sv
// Shared types for the PC sequencer: FSM states, indirect-flow kinds and width defaults.
// decode_kind() resolves the js > jmem > bmem priority for memory-indirect instructions.
package pc_sequencer_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_IND_RD = 2'd1,
        ST_IND_WR = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_JS   = 2'd1,
        KIND_JMEM = 2'd2,
        KIND_BMEM = 2'd3
    } kind_e;

    function automatic kind_e decode_kind(logic js, logic jmem, logic bmem, logic cmp_eq);
        kind_e k;
        k = KIND_NONE;
        if (js)
            k = KIND_JS;
        else if (jmem)
            k = KIND_JMEM;
        else if (bmem && cmp_eq)
            k = KIND_BMEM;
        return k;
    endfunction

endpackage

// File: rtl/pc_sequencer_ind_timeout_ctr.sv
// Watchdog for one indirect memory access: cleared on entry, counts cycles without
// ready, and flags expiry in the TIMEOUT-th such cycle.
module ind_timeout_ctr #(
    parameter int TIMEOUT = 16,
    localparam int CW     = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expire_o = en_i && !clear_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// PC owner and next-PC logic for the extended MIPS core, including memory-indirect
// jmem/bmem/js flows over a req/ready data-memory port.
//
// Handshake: ind_req/ind_we/ind_addr/ind_wdata are registered and held stable while
// ind_req=1; an access completes in any cycle where ind_req=1 and ind_ready=1, and
// ind_req drops (or a js read turns into its write) on the following edge.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic              branch,
    input  logic              zero,
    input  logic              jmem,
    input  logic              bmem,
    input  logic              cmp_eq,
    input  logic              js,
    input  logic [ADDR_W-1:0] imm_ext,
    input  logic [ADDR_W-1:0] ind_base,
    output logic              ind_req,
    output logic              ind_we,
    output logic [ADDR_W-1:0] ind_addr,
    output logic [ADDR_W-1:0] ind_wdata,
    input  logic [ADDR_W-1:0] ind_rdata,
    input  logic              ind_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              stall,
    output logic              fault,
    output logic [1:0]        state_dbg
);

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    kind_e             new_kind;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [ADDR_W-1:0] rdata_aligned;
    logic              fault_q, fault_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              ctr_clr, ctr_en, ctr_expire;

    assign pc_plus4      = pc_q + ADDR_W'(4);
    assign new_kind      = decode_kind(js, jmem, bmem, cmp_eq);
    assign rdata_aligned = {ind_rdata[ADDR_W-1:2], 2'b00};

    ind_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (ctr_clr),
        .en_i     (ctr_en),
        .expire_o (ctr_expire)
    );

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        target_d = target_q;
        fault_d  = fault_q;
        req_d    = req_q;
        we_d     = we_q;
        stall    = 1'b0;
        ctr_clr  = 1'b0;
        ctr_en   = 1'b0;
        case (state_q)
            ST_RUN: begin
                ctr_clr = 1'b1;
                if (instr_valid) begin
                    if (new_kind != KIND_NONE) begin
                        kind_d  = new_kind;
                        addr_d  = ind_base;
                        wdata_d = pc_plus4;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        stall   = 1'b1;
                        state_d = ST_IND_RD;
                    end else if (bmem) begin
                        pc_d = pc_plus4;
                    end else if (branch && zero) begin
                        pc_d = pc_plus4 + (imm_ext << 2);
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            ST_IND_RD: begin
                stall  = 1'b1;
                ctr_en = !ind_ready;
                if (ind_ready) begin
                    if (ind_rdata[1:0] != 2'b00)
                        fault_d = 1'b1;
                    if (kind_q == KIND_JS) begin
                        target_d = rdata_aligned;
                        we_d     = 1'b1;
                        ctr_clr  = 1'b1;
                        state_d  = ST_IND_WR;
                    end else begin
                        pc_d    = rdata_aligned;
                        req_d   = 1'b0;
                        state_d = ST_RUN;
                    end
                end else if (ctr_expire) begin
                    // Abandon the access and fall through to the next sequential instruction.
                    fault_d = 1'b1;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    pc_d    = wdata_q;
                    state_d = ST_RUN;
                end
            end
            ST_IND_WR: begin
                stall  = 1'b1;
                ctr_en = !ind_ready;
                if (ind_ready) begin
                    pc_d    = target_q;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = ST_RUN;
                end else if (ctr_expire) begin
                    fault_d = 1'b1;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    pc_d    = wdata_q;
                    state_d = ST_RUN;
                end
            end
            default: begin
                req_d   = 1'b0;
                we_d    = 1'b0;
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            kind_q   <= KIND_NONE;
            pc_q     <= RESET_PC;
            addr_q   <= '0;
            wdata_q  <= '0;
            target_q <= '0;
            fault_q  <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            target_q <= target_d;
            fault_q  <= fault_d;
            req_q    <= req_d;
            we_q     <= we_d;
        end
    end

    assign pc        = pc_q;
    assign ind_req   = req_q;
    assign ind_we    = we_q;
    assign ind_addr  = addr_q;
    assign ind_wdata = wdata_q;
    assign fault     = fault_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: drives decoded instructions, plays the data-memory side of
// the indirect handshake, and compares the resulting PC against a queue of expectations.
module tb_pc_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid, branch, zero, jmem, bmem, cmp_eq, js;
    logic [31:0] imm_ext, ind_base, ind_rdata;
    logic        ind_ready;
    logic        ind_req, ind_we, stall, fault;
    logic [31:0] ind_addr, ind_wdata, pc, pc_plus4;
    logic [1:0]  state_dbg;

    logic [31:0] exp_q[$];
    logic [31:0] cur_pc;
    int          n_vec  = 0;
    int          n_miss = 0;

    pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .branch(branch),
        .zero(zero), .jmem(jmem), .bmem(bmem), .cmp_eq(cmp_eq), .js(js),
        .imm_ext(imm_ext), .ind_base(ind_base), .ind_req(ind_req), .ind_we(ind_we),
        .ind_addr(ind_addr), .ind_wdata(ind_wdata), .ind_rdata(ind_rdata),
        .ind_ready(ind_ready), .pc(pc), .pc_plus4(pc_plus4), .stall(stall),
        .fault(fault), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        instr_valid = 1'b0; branch = 1'b0; zero = 1'b0; jmem = 1'b0;
        bmem = 1'b0; cmp_eq = 1'b0; js = 1'b0;
        imm_ext = $urandom; ind_base = $urandom;
    endtask

    // rd_lat: cycles until the read completes (0 = never, exercising the timeout);
    // wr_lat: cycles until the js write completes.
    task automatic do_instr(input string tag, input logic br, input logic z, input logic jm,
                            input logic bm, input logic ceq, input logic j,
                            input logic [31:0] imm, input logic [31:0] base,
                            input logic [31:0] rd, input int rd_lat, input int wr_lat,
                            input logic [31:0] exp_pc, input logic exp_fault);
        logic        is_ind;
        logic [31:0] link;
        is_ind = j | jm | (bm & ceq);
        link   = cur_pc + 32'd4;
        @(negedge clk);
        instr_valid = 1'b1; branch = br; zero = z; jmem = jm; bmem = bm;
        cmp_eq = ceq; js = j; imm_ext = imm; ind_base = base;
        exp_q.push_back(exp_pc);
        #1;
        check_val({tag, ".stall_issue"}, stall, is_ind);
        @(posedge clk);
        #1;
        clear_inputs();
        if (is_ind) begin
            for (int c = 0; c < ((rd_lat == 0) ? TO : rd_lat); c++) begin
                @(negedge clk);
                check_val({tag, ".rd_req"}, {ind_req, ind_we, stall}, 3'b101);
                check_val({tag, ".rd_addr"}, ind_addr, base);
                if (rd_lat == 0)
                    check_val({tag, ".fault_pre"}, fault, 1'b0);
                if (rd_lat != 0 && c == rd_lat - 1) begin
                    ind_ready = 1'b1;
                    ind_rdata = rd;
                end else begin
                    ind_rdata = $urandom;
                end
                @(posedge clk);
                #1;
                ind_ready = 1'b0;
            end
            if (j && rd_lat != 0) begin
                for (int c = 0; c < wr_lat; c++) begin
                    @(negedge clk);
                    check_val({tag, ".wr_req"}, {ind_req, ind_we, stall}, 3'b111);
                    check_val({tag, ".wr_addr"}, ind_addr, base);
                    check_val({tag, ".wr_data"}, ind_wdata, link);
                    ind_ready = (c == wr_lat - 1);
                    @(posedge clk);
                    #1;
                    ind_ready = 1'b0;
                end
            end
        end
        @(negedge clk);
        check_val({tag, ".req_idle"}, ind_req, 1'b0);
        check_val({tag, ".stall_idle"}, stall, 1'b0);
        check_val({tag, ".fault"}, fault, exp_fault);
        if (exp_q.size() == 0) begin
            check_val({tag, ".queue_empty"}, 32'd1, 32'd0);
        end else begin
            check_val({tag, ".pc"}, pc, exp_q.pop_front());
        end
        cur_pc = exp_pc;
    endtask

    initial begin
        clear_inputs();
        ind_ready = 1'b0;
        ind_rdata = '0;
        rst_n     = 1'b0;
        cur_pc    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("reset.pc", pc, 32'h0);
        check_val("reset.ctl", {ind_req, ind_we, stall, fault}, 4'b0000);
        check_val("reset.pc4", pc_plus4, 32'h4);

        // sequential flow, then an idle cycle where pc must hold
        do_instr("plain0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0);
        do_instr("plain1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 0);
        do_instr("plain2", 1, 0, 0, 0, 0, 0, 32'h10, 0, 0, 0, 0, 32'hC, 0);
        repeat (2) @(negedge clk);
        check_val("idle.pc", pc, 32'hC);

        // beq: taken forward, taken backward (negative imm), not taken
        do_instr("br_fwd", 1, 1, 0, 0, 0, 0, 32'd12, 0, 0, 0, 0, 32'h40, 0);
        do_instr("br_neg", 1, 1, 0, 0, 0, 0, 32'hFFFF_FFFE, 0, 0, 0, 0, 32'h3C, 0);
        do_instr("br_nt0", 1, 0, 0, 0, 0, 0, 32'h55, 0, 0, 0, 0, 32'h40, 0);
        do_instr("br_nt1", 1, 0, 0, 0, 0, 0, 32'h55, 0, 0, 0, 0, 32'h44, 0);
        do_instr("br_to100", 1, 1, 0, 0, 0, 0, 32'h2E, 0, 0, 0, 0, 32'h100, 0);

        do_instr("jmem", 0, 0, 1, 0, 0, 0, 0, 32'h2000, 32'h800, 3, 0, 32'h800, 0);
        do_instr("br_to200", 1, 1, 0, 0, 0, 0, 32'hFFFF_FE7F, 0, 0, 0, 0, 32'h200, 0);
        do_instr("js", 0, 0, 0, 0, 0, 1, 0, 32'h3000, 32'h900, 2, 1, 32'h900, 0);
        do_instr("bmem_nt", 1, 1, 0, 1, 0, 0, 32'h40, 32'h4000, 0, 0, 0, 32'h904, 0);
        do_instr("bmem_t", 0, 0, 0, 1, 1, 0, 0, 32'h4100, 32'hA00, 1, 0, 32'hA00, 0);
        do_instr("js_prio", 0, 0, 1, 0, 0, 1, 0, 32'h5000, 32'hB00, 1, 2, 32'hB00, 0);
        do_instr("jmem_mis", 0, 0, 1, 0, 0, 0, 0, 32'h2000, 32'h803, 2, 0, 32'h800, 1);

        // reset in the middle of an indirect read
        @(negedge clk);
        instr_valid = 1'b1; jmem = 1'b1; ind_base = 32'h6000;
        @(posedge clk);
        #1;
        clear_inputs();
        @(negedge clk);
        check_val("rstmid.req_before", ind_req, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rstmid.ctl", {ind_req, ind_we, stall, fault}, 4'b0000);
        check_val("rstmid.pc", pc, 32'h0);
        check_val("rstmid.state", state_dbg, 2'd0);
        cur_pc = 32'h0;

        do_instr("timeout", 0, 0, 1, 0, 0, 0, 0, 32'h7000, 0, 0, 0, 32'h4, 1);
        do_instr("after_to", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 1);

        check_val("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
